// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/host/dmem signal bundle for the data memory arbiter
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          core_rvalid;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_dout,
    output core_gnt, core_stall, core_rdata, core_rvalid,
    output host_gnt, host_rdata, host_rvalid,
    output mem_we, mem_addr, mem_di
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_dout,
    input  core_gnt, core_stall, core_rdata, core_rvalid,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port dmem arbiter, core priority with host starvation guard
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {CORE_PRI, HOST_PRI} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          core_gnt, host_gnt;
  logic [DW-1:0] core_rdata_q, host_rdata_q;
  logic          core_rvalid_q, host_rvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CORE_PRI;
      starve_q      <= '0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      core_rvalid_q <= core_gnt & ~bus.core_we;
      host_rvalid_q <= host_gnt & ~bus.host_we;
      if (core_gnt && !bus.core_we) core_rdata_q <= bus.mem_dout;
      if (host_gnt && !bus.host_we) host_rdata_q <= bus.mem_dout;
    end
  end

  // Grants are masked during reset so no write can reach dmem while it is asserted.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (!reset) begin
      if (state_q == HOST_PRI) begin
        host_gnt = bus.host_req;
        core_gnt = bus.core_req & ~bus.host_req;
      end else begin
        core_gnt = bus.core_req;
        host_gnt = bus.host_req & ~bus.core_req;
      end
    end
    if (!bus.host_req || host_gnt) starve_d = '0;
    else if (starve_q != SMAX) starve_d = starve_q + CW'(1);
    if (state_q == CORE_PRI) begin
      if (starve_d == SMAX) state_d = HOST_PRI;
    end else begin
      if (host_gnt || !bus.host_req) state_d = CORE_PRI;
    end
  end

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_di   = '0;
    if (core_gnt) begin
      bus.mem_we   = bus.core_we;
      bus.mem_addr = bus.core_addr;
      bus.mem_di   = bus.core_wdata;
    end else if (host_gnt) begin
      bus.mem_we   = bus.host_we;
      bus.mem_addr = bus.host_addr;
      bus.mem_di   = bus.host_wdata;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
endmodule
